// File: rtl/pwm_fader.sv
// Brightness fader: accepts a target over valid/ready and ramps `level` toward it
// by a programmed step on every prescaler tick, pulsing `done` on arrival.
module pwm_fader #(
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 200000,
    parameter int MAX_LEVEL = 255,
    parameter int RATE_W    = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [WIDTH-1:0]  tgt_level,
    input  logic [RATE_W-1:0] tgt_rate,
    input  logic              freeze,
    output logic [WIDTH-1:0]  level,
    output logic              busy,
    output logic              done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_RELOAD = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_L      = WIDTH'(MAX_LEVEL);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     presc, presc_next;
    logic [WIDTH-1:0]  target, target_next;
    logic [WIDTH-1:0]  level_next, stepped;
    logic [RATE_W-1:0] step, step_next;
    logic              done_next;
    logic [WIDTH-1:0]  clamped;
    logic [RATE_W-1:0] rate_eff;
    logic [WIDTH:0]    gap, step_ext;

    // One extra bit of headroom keeps the step from wrapping past 0 or 2^WIDTH-1.
    always_comb begin
        clamped  = (tgt_level > MAX_L) ? MAX_L : tgt_level;
        rate_eff = (tgt_rate == '0) ? RATE_W'(1) : tgt_rate;
        step_ext = (WIDTH+1)'(step);
        gap      = (level < target) ? ({1'b0, target} - {1'b0, level})
                                    : ({1'b0, level} - {1'b0, target});
        if (gap <= step_ext)
            stepped = target;
        else if (level < target)
            stepped = level + step_ext[WIDTH-1:0];
        else
            stepped = level - step_ext[WIDTH-1:0];
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_next  = state;
        presc_next  = presc;
        target_next = target;
        step_next   = step;
        level_next  = level;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    target_next = clamped;
                    step_next   = rate_eff;
                    presc_next  = PRE_RELOAD;
                    if (clamped == level)
                        done_next = 1'b1;
                    else
                        state_next = RAMP;
                end
            end
            RAMP: begin
                if (!freeze) begin
                    if (presc == '0) begin
                        presc_next = PRE_RELOAD;
                        level_next = stepped;
                        if (stepped == target) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        presc_next = presc - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            presc  <= PRE_RELOAD;
            target <= '0;
            step   <= RATE_W'(1);
            level  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            presc  <= presc_next;
            target <= target_next;
            step   <= step_next;
            level  <= level_next;
            done   <= done_next;
        end
    end

    assign busy      = (state == RAMP);
    assign tgt_ready = (state == IDLE) && sys_rst_n;

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: directed and random fades compared against
// a tick-count model of where the level should be after each cycle.
module tb_pwm_fader;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       tgt_valid;
    logic [7:0] tgt_level;
    logic [3:0] tgt_rate;
    logic       freeze;
    logic       sel;

    logic       valid_a, ready_a, busy_a, done_a;
    logic       valid_b, ready_b, busy_b, done_b;
    logic [7:0] level_a, level_b;
    logic       o_ready, o_busy, o_done;
    logic [7:0] o_level;

    int errors = 0;
    int checks = 0;
    int m_level[2];

    always #5 clk = ~clk;

    assign valid_a = tgt_valid && !sel;
    assign valid_b = tgt_valid && sel;
    assign o_ready = sel ? ready_b : ready_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_level = sel ? level_b : level_a;

    pwm_fader #(.WIDTH(8), .PRESCALE(PRESCALE), .MAX_LEVEL(255), .RATE_W(4)) dut_a (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .tgt_valid(valid_a), .tgt_ready(ready_a),
        .tgt_level(tgt_level), .tgt_rate(tgt_rate), .freeze(freeze),
        .level(level_a), .busy(busy_a), .done(done_a)
    );

    pwm_fader #(.WIDTH(8), .PRESCALE(PRESCALE), .MAX_LEVEL(80), .RATE_W(4)) dut_b (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .tgt_valid(valid_b), .tgt_ready(ready_b),
        .tgt_level(tgt_level), .tgt_rate(tgt_rate), .freeze(freeze),
        .level(level_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int toward(input int s, input int t, input int moved);
        if (t > s) return (s + moved > t) ? t : s + moved;
        return (s - moved < t) ? t : s - moved;
    endfunction

    // Issue one command and follow it to completion. Expected level after each cycle
    // is the start moved toward the target by (ticks so far) * step, where a tick
    // falls every PRESCALE unfrozen cycles after the accept.
    task automatic cmd(input int tl, input int tr, input int fz_at, input int fz_len, input bit hold);
        int  max_l, tgt, stp, start, active, exp_l;
        bit  reached;
        max_l = sel ? 80 : 255;
        tgt   = (tl > max_l) ? max_l : tl;
        stp   = (tr == 0) ? 1 : tr;
        start = m_level[sel];
        tgt_valid = 1'b1;
        tgt_level = 8'(tl);
        tgt_rate  = 4'(tr);
        freeze    = 1'b0;
        check("ready_before_accept", 32'(o_ready), 1);
        step_cycle();
        tgt_valid = 1'b0;
        tgt_level = 8'($urandom);
        tgt_rate  = 4'($urandom);
        if (tgt == start) begin
            check("same_done", 32'(o_done), 1);
            check("same_busy", 32'(o_busy), 0);
            check("same_level", 32'(o_level), 32'(start));
            step_cycle();
            check("same_done_clear", 32'(o_done), 0);
            return;
        end
        check("accept_busy", 32'(o_busy), 1);
        check("accept_ready", 32'(o_ready), 0);
        active  = 0;
        reached = 1'b0;
        for (int c = 1; c <= 2000 && !reached; c++) begin
            freeze = (fz_len > 0) && (c >= fz_at) && (c < fz_at + fz_len);
            if (hold) begin
                tgt_valid = 1'b1;
                tgt_level = 8'd50;
                tgt_rate  = 4'd2;
            end else begin
                tgt_valid = 1'($urandom_range(0, 1));
            end
            if (!freeze) active++;
            step_cycle();
            exp_l   = toward(start, tgt, (active / PRESCALE) * stp);
            reached = (exp_l == tgt);
            check("ramp_level", 32'(o_level), 32'(exp_l));
            check("ramp_busy", 32'(o_busy), 32'(!reached));
            check("ramp_done", 32'(o_done), 32'(reached));
            check("ramp_ready", 32'(o_ready), 32'(reached));
        end
        freeze = 1'b0;
        if (!hold) tgt_valid = 1'b0;
        if (!reached) check("ramp_timeout", 0, 1);
        m_level[sel] = tgt;
        if (!hold) begin
            step_cycle();
            check("done_one_cycle", 32'(o_done), 0);
            check("idle_busy", 32'(o_busy), 0);
            check("idle_level", 32'(o_level), 32'(tgt));
        end
    endtask

    initial begin
        sel       = 1'b0;
        sys_rst_n = 1'b0;
        tgt_valid = 1'b0;
        tgt_level = '0;
        tgt_rate  = '0;
        freeze    = 1'b0;
        m_level   = '{0, 0};

        // Reset held for three cycles
        repeat (3) begin
            step_cycle();
            check("ready_in_reset", 32'(o_ready), 0);
        end
        sys_rst_n = 1'b1;
        #1;
        check("rst_level", 32'(o_level), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("ready_after_reset", 32'(o_ready), 1);

        // Up-ramp, down-ramp to 0, saturation at the top
        cmd(10, 3, 0, 0, 1'b0);
        cmd(0, 4, 0, 0, 1'b0);
        cmd(250, 15, 0, 0, 1'b0);
        cmd(255, 15, 0, 0, 1'b0);
        cmd(240, 9, 0, 0, 1'b0);

        // Valid held during a ramp, then accepted on the done cycle with a freeze window
        cmd(100, 5, 0, 0, 1'b1);
        cmd(50, 2, 5, 6, 1'b0);
        cmd(0, 15, 0, 0, 1'b0);

        // Reset mid-ramp at level 6 of a 0 -> 10 fade
        tgt_valid = 1'b1;
        tgt_level = 8'd10;
        tgt_rate  = 4'd3;
        step_cycle();
        tgt_valid = 1'b0;
        repeat (8) step_cycle();
        check("pre_abort_level", 32'(o_level), 6);
        sys_rst_n = 1'b0;
        #1;
        check("abort_ready_gated", 32'(o_ready), 0);
        step_cycle();
        check("abort_level", 32'(o_level), 0);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_done", 32'(o_done), 0);
        sys_rst_n = 1'b1;
        #1;
        check("abort_ready", 32'(o_ready), 1);
        step_cycle();
        check("abort_no_done", 32'(o_done), 0);
        m_level = '{0, 0};

        // Clamp to MAX_LEVEL=80 with rate 0, then a no-op target
        sel = 1'b1;
        #1;
        cmd(200, 0, 0, 0, 1'b0);
        cmd(80, 5, 0, 0, 1'b0);
        sel = 1'b0;
        #1;

        // Random fades with random freeze windows
        for (int i = 0; i < 8; i++)
            cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                int'($urandom_range(1, 20)), int'($urandom_range(0, 5)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
